// File: rtl/cart_bus_sequencer.sv
// Cartridge bus sequencer: arbitrates CPU and backup-engine access to the cart bus and
// inserts mapper RAM-enable / bank-select cycles ahead of backup SRAM accesses.
module cart_bus_sequencer #(
    parameter int         STROBE_CYC = 2,
    parameter logic [7:0] RAMEN_VAL  = 8'h0A
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        bk_active,
    input  logic        bk_req,
    input  logic        bk_we,
    input  logic [16:0] bk_addr,
    input  logic [7:0]  bk_wdata,
    output logic [7:0]  bk_rdata,
    output logic        bk_ack,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    input  logic [7:0]  bus_din,
    output logic        bus_nrd,
    output logic        bus_nwr,
    output logic        bus_ncs,
    output logic        busy
);
    // state  | meaning
    // IDLE   | bus parked, arbitrating between cpu, session close and backup
    // SETUP  | addr/dout/oe/ncs driven, strobes still high
    // STROBE | nrd or nwr low for STROBE_CYC clocks
    // HOLD   | strobes high, addr/ncs held; ack on the final cycle of an access
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    typedef enum logic [2:0] {OP_CPU, OP_RAMEN, OP_BANK, OP_SRAM, OP_CLOSE} op_t;

    state_t      state;
    op_t         op;
    op_t         bk_op;
    op_t         start_op;
    logic        start_valid;
    logic [15:0] start_addr;
    logic [7:0]  start_data;
    logic        start_we;
    logic        op_we;
    logic [3:0]  strb_cnt;
    logic        ram_en_valid;
    logic        bank_valid;
    logic [3:0]  cur_bank;
    logic        close_pend;
    logic        bk_active_d;

    assign busy = (state != IDLE);

    // Next backup micro-op; flags are updated when a config cycle starts, so in its
    // HOLD this already points at the following step.
    always_comb begin
        if (!ram_en_valid)
            bk_op = OP_RAMEN;
        else if (!bank_valid || cur_bank != bk_addr[16:13])
            bk_op = OP_BANK;
        else
            bk_op = OP_SRAM;
    end

    always_comb begin
        start_valid = 1'b0;
        start_op    = OP_CPU;
        if (state == IDLE) begin
            if (cpu_req) begin
                start_valid = 1'b1;
            end else if (close_pend) begin
                start_valid = 1'b1;
                start_op    = OP_CLOSE;
            end else if (bk_req) begin
                start_valid = 1'b1;
                start_op    = bk_op;
            end
        end else if (state == HOLD && (op == OP_RAMEN || op == OP_BANK)) begin
            start_valid = 1'b1;
            start_op    = bk_op;
        end
    end

    always_comb begin
        start_addr = cpu_addr;
        start_data = cpu_wdata;
        start_we   = cpu_we;
        case (start_op)
            OP_RAMEN: begin
                start_addr = 16'h0000;
                start_data = RAMEN_VAL;
                start_we   = 1'b1;
            end
            OP_BANK: begin
                start_addr = 16'h4000;
                start_data = {4'h0, bk_addr[16:13]};
                start_we   = 1'b1;
            end
            OP_SRAM: begin
                start_addr = {3'b101, bk_addr[12:0]};
                start_data = bk_wdata;
                start_we   = bk_we;
            end
            OP_CLOSE: begin
                start_addr = 16'h0000;
                start_data = 8'h00;
                start_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op           <= OP_CPU;
            op_we        <= 1'b0;
            strb_cnt     <= 4'd0;
            bus_addr     <= 16'h0000;
            bus_dout     <= 8'h00;
            bus_oe       <= 1'b0;
            bus_nrd      <= 1'b1;
            bus_nwr      <= 1'b1;
            bus_ncs      <= 1'b1;
            cpu_ack      <= 1'b0;
            bk_ack       <= 1'b0;
            cpu_rdata    <= 8'h00;
            bk_rdata     <= 8'h00;
            ram_en_valid <= 1'b0;
            bank_valid   <= 1'b0;
            cur_bank     <= 4'h0;
            close_pend   <= 1'b0;
            bk_active_d  <= 1'b0;
        end else begin
            cpu_ack     <= 1'b0;
            bk_ack      <= 1'b0;
            bk_active_d <= bk_active;
            if (bk_active_d && !bk_active && ram_en_valid)
                close_pend <= 1'b1;
            case (state)
                IDLE, HOLD: begin
                    if (start_valid) begin
                        state    <= SETUP;
                        op       <= start_op;
                        op_we    <= start_we;
                        bus_addr <= start_addr;
                        bus_dout <= start_data;
                        bus_oe   <= start_we;
                        bus_ncs  <= !(start_addr[15:13] == 3'b101);
                        case (start_op)
                            OP_RAMEN: ram_en_valid <= 1'b1;
                            OP_BANK: begin
                                bank_valid <= 1'b1;
                                cur_bank   <= bk_addr[16:13];
                            end
                            OP_CLOSE: begin
                                ram_en_valid <= 1'b0;
                                bank_valid   <= 1'b0;
                                close_pend   <= 1'b0;
                            end
                            OP_CPU: begin
                                // CPU poking the mapper invalidates our cached view of it
                                if (cpu_we && cpu_addr[15:13] == 3'b000)
                                    ram_en_valid <= 1'b0;
                                if (cpu_we && cpu_addr[15:13] == 3'b010)
                                    bank_valid <= 1'b0;
                            end
                            default: ;
                        endcase
                    end else begin
                        state   <= IDLE;
                        bus_oe  <= 1'b0;
                        bus_ncs <= 1'b1;
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    strb_cnt <= 4'(STROBE_CYC - 1);
                    if (op_we)
                        bus_nwr <= 1'b0;
                    else
                        bus_nrd <= 1'b0;
                end
                STROBE: begin
                    if (strb_cnt == 4'd0) begin
                        state   <= HOLD;
                        bus_nrd <= 1'b1;
                        bus_nwr <= 1'b1;
                        if (op == OP_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!op_we)
                                cpu_rdata <= bus_din;
                        end
                        if (op == OP_SRAM) begin
                            bk_ack <= 1'b1;
                            if (!op_we)
                                bk_rdata <= bus_din;
                        end
                    end else begin
                        strb_cnt <= strb_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cart_bus_sequencer.sv
// Self-checking bench for cart_bus_sequencer: expected bus cycles are queued as
// stimulus is issued and checked by a bus monitor as each cycle completes.
module tb_cart_bus_sequencer;
    localparam int SC = 2;

    logic        clk_sys, reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        bk_active, bk_req, bk_we, bk_ack;
    logic [16:0] bk_addr;
    logic [7:0]  bk_wdata, bk_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, bus_din;
    logic        bus_oe, bus_nrd, bus_nwr, bus_ncs, busy;

    cart_bus_sequencer #(.STROBE_CYC(SC), .RAMEN_VAL(8'h0A)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .bk_active(bk_active), .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr),
        .bk_wdata(bk_wdata), .bk_rdata(bk_rdata), .bk_ack(bk_ack),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
        .bus_nrd(bus_nrd), .bus_nwr(bus_nwr), .bus_ncs(bus_ncs), .busy(busy)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cpu_ack_cnt = 0;
    int   bk_ack_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic we, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.we = we;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Bus monitor: captures a cycle at its first strobe-low sample, checks it in HOLD
    logic        in_cyc = 1'b0;
    logic        m_we, m_ncs, m_oe;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    int          m_len;

    always @(negedge clk_sys) begin
        if (cpu_ack === 1'b1) cpu_ack_cnt++;
        if (bk_ack === 1'b1) bk_ack_cnt++;
        if (reset) begin
            in_cyc = 1'b0;
        end else if (!bus_nrd || !bus_nwr) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                m_we   = !bus_nwr;
                m_addr = bus_addr;
                m_data = bus_dout;
                m_ncs  = bus_ncs;
                m_oe   = bus_oe;
                m_len  = 0;
            end
            m_len++;
        end else if (in_cyc) begin
            exp_t e;
            in_cyc = 1'b0;
            if (sb.size() == 0) begin
                check("sb_unexpected_cycle_addr", {16'h0, m_addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("cyc_we", m_we, e.we);
                check("cyc_addr", m_addr, e.addr);
                if (e.we) check("cyc_wdata", m_data, e.data);
                check("cyc_ncs", m_ncs, (e.addr[15:13] == 3'b101) ? 1'b0 : 1'b1);
                check("cyc_oe", m_oe, e.we);
                check("cyc_strobe_len", m_len, SC);
                check("hold_ncs", bus_ncs, (e.addr[15:13] == 3'b101) ? 1'b0 : 1'b1);
                check("hold_oe", bus_oe, e.we);
                check("hold_addr", bus_addr, e.addr);
            end
        end
    end

    task automatic wait_ack(input bit is_bk, input int exp_lat, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(posedge clk_sys);
            #1;
            n++;
            seen = is_bk ? bk_ack : cpu_ack;
        end
        check({tag, "_seen"}, seen, 1'b1);
        check({tag, "_lat"}, n, exp_lat);
        @(posedge clk_sys);
        #1;
        check({tag, "_ack_pulse"}, is_bk ? bk_ack : cpu_ack, 1'b0);
    endtask

    task automatic cpu_xfer(input logic we, input logic [15:0] a, input logic [7:0] wd,
                            input logic [7:0] din, input int exp_lat, input string tag);
        int c0 = cpu_ack_cnt;
        push(we, a, wd);
        bus_din = din; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        wait_ack(1'b0, exp_lat, tag);
        cpu_req = 1'b0;
        if (!we) check({tag, "_rdata"}, cpu_rdata, din);
        check({tag, "_ack_count"}, cpu_ack_cnt - c0, 1);
    endtask

    task automatic bk_xfer(input logic we, input logic [16:0] a, input logic [7:0] wd,
                           input logic [7:0] din, input int exp_lat, input string tag);
        int c0 = bk_ack_cnt;
        push(we, {3'b101, a[12:0]}, wd);
        bus_din = din; bk_we = we; bk_addr = a; bk_wdata = wd; bk_req = 1'b1;
        wait_ack(1'b1, exp_lat, tag);
        bk_req = 1'b0;
        if (!we) check({tag, "_rdata"}, bk_rdata, din);
        check({tag, "_ack_count"}, bk_ack_cnt - c0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int c0;
        int n;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        bk_active = 0; bk_req = 0; bk_we = 0; bk_addr = 0; bk_wdata = 0; bus_din = 0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_strobes", {bus_nrd, bus_nwr, bus_ncs, bus_oe}, 4'b1110);
        check("rst_addr_dout", {bus_addr, bus_dout}, 24'h0);
        check("rst_acks_busy", {cpu_ack, bk_ack, busy}, 3'b000);
        check("rst_rdata", {cpu_rdata, bk_rdata}, 16'h0);
        reset = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if ({bus_nrd, bus_nwr, bus_ncs, bus_oe, busy, cpu_ack, bk_ack} !== 7'b1110000) bad++;
        end
        check("idle_quiet", bad, 0);
        @(posedge clk_sys);
        #1;

        cpu_xfer(1'b0, 16'h0150, 8'h00, 8'h3C, 2 + SC, "cpu_rd_0150");

        bk_active = 1'b1;
        push(1'b1, 16'h0000, 8'h0A);
        push(1'b1, 16'h4000, 8'h01);
        bk_xfer(1'b1, 17'h0_2005, 8'h77, 8'h00, 3 * (2 + SC), "bk_wr_full");
        bk_xfer(1'b0, 17'h0_2006, 8'h00, 8'h5A, 2 + SC, "bk_rd_single");

        // Simultaneous requests: CPU first, backup granted in the following IDLE
        push(1'b0, 16'hB0FF, 8'h00);
        push(1'b1, 16'hA009, 8'h11);
        bus_din = 8'h99;
        cpu_we = 1'b0; cpu_addr = 16'hB0FF; cpu_req = 1'b1;
        bk_we = 1'b1; bk_addr = 17'h0_2009; bk_wdata = 8'h11; bk_req = 1'b1;
        wait_ack(1'b0, 2 + SC, "arb_cpu");
        cpu_req = 1'b0;
        check("arb_cpu_rdata", cpu_rdata, 8'h99);
        wait_ack(1'b1, 2 + SC, "arb_bk");
        bk_req = 1'b0;

        cpu_xfer(1'b1, 16'h4000, 8'h03, 8'h00, 2 + SC, "cpu_wr_bank");
        push(1'b1, 16'h4000, 8'h01);
        bk_xfer(1'b1, 17'h0_2007, 8'h42, 8'h00, 2 * (2 + SC), "bk_rebank");

        // Session end: one mapper RAM-disable write, no acks
        c0 = cpu_ack_cnt + bk_ack_cnt;
        push(1'b1, 16'h0000, 8'h00);
        bk_active = 1'b0;
        n = 0;
        while (!busy && n < 20) begin @(posedge clk_sys); #1; n++; end
        while (busy && n < 40) begin @(posedge clk_sys); #1; n++; end
        check("close_done_idle", busy, 1'b0);
        check("close_no_ack", cpu_ack_cnt + bk_ack_cnt - c0, 0);
        @(posedge clk_sys);
        #1;

        bk_active = 1'b1;
        push(1'b1, 16'h0000, 8'h0A);
        push(1'b1, 16'h4000, 8'h01);
        bk_xfer(1'b1, 17'h0_2008, 8'hC3, 8'h00, 3 * (2 + SC), "bk_after_close");

        // Reset in the STROBE phase of an SRAM write
        push(1'b1, 16'h4000, 8'h02);
        c0 = bk_ack_cnt;
        bk_we = 1'b1; bk_addr = 17'h0_4010; bk_wdata = 8'hE1; bk_req = 1'b1;
        n = 0;
        while (!(bus_nwr === 1'b0 && bus_ncs === 1'b0) && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        check("rst_mid_reached_sram_strobe", {bus_nwr, bus_ncs}, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_strobes", {bus_nrd, bus_nwr, bus_ncs, bus_oe}, 4'b1110);
        check("rst_mid_busy_addr", {busy, bus_addr}, 17'h0);
        check("rst_mid_rdata", {cpu_rdata, bk_rdata}, 16'h0);
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_mid_no_ack", bk_ack_cnt - c0, 0);
        reset = 1'b0;
        push(1'b1, 16'h0000, 8'h0A);
        push(1'b1, 16'h4000, 8'h02);
        bk_xfer(1'b1, 17'h0_4010, 8'hE1, 8'h00, 3 * (2 + SC), "rst_reissue");

        repeat (3) @(posedge clk_sys);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
